stump_sequencer: RTL and testbench

STUMP_SEQUENCER -- requirements
Module: stump_sequencer

---
 rtl/stump_sequencer_pkg.sv | 19 +
 rtl/stump_sequencer_if.sv | 24 ++
 rtl/stump_retire_counter.sv | 18 +
 rtl/stump_sequencer.sv | 91 +++++++++
 tb/tb_stump_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/stump_sequencer_pkg.sv
// Shared Stump definitions: sequencer state codes and opcode constants,
// also used by the control decoder.
package stump_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;

    function automatic logic is_ldst(input logic [2:0] opcode);
        return opcode == OP_LDST;
    endfunction

endpackage

// File: rtl/stump_sequencer_if.sv
// Memory handshake, ALU flags and sequencer status bundle.
interface stump_sequencer_if;

    logic [15:0] mem_data_in;
    logic        mem_ready;
    logic [3:0]  flags_in;
    logic        cc_en;
    logic [1:0]  state;
    logic [15:0] ir;
    logic [3:0]  cc;
    logic [15:0] retired;
    logic        stall;

    modport master (
        output mem_data_in, mem_ready, flags_in, cc_en,
        input  state, ir, cc, retired, stall
    );

    modport slave (
        input  mem_data_in, mem_ready, flags_in, cc_en,
        output state, ir, cc, retired, stall
    );

endinterface

// File: rtl/stump_retire_counter.sv
// 16-bit retired-instruction counter with enable, natural wrap and async clear.
module stump_retire_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] count
);

    // Adding the enable keeps the register written every cycle; it holds when en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count + 16'(en);
        end
    end

endmodule

// File: rtl/stump_sequencer.sv
// Stump fetch/execute/memory sequencer: FSM, instruction register,
// condition-code register and retire counter.
module stump_sequencer
    import stump_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    stump_sequencer_if.slave   bus
);

    state_t      state_r;
    state_t      state_nx;
    logic [15:0] ir_r;
    logic [3:0]  cc_r;
    logic [15:0] retired_cnt;
    logic        ir_ld;
    logic        cc_ld;
    logic        retire_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state_r;
        ir_ld     = 1'b0;
        cc_ld     = 1'b0;
        retire_en = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_nx = ST_EXECUTE;
                    ir_ld    = 1'b1;
                end
            end
            ST_EXECUTE: begin
                cc_ld = bus.cc_en;
                if (is_ldst(ir_r[15:13])) begin
                    state_nx = ST_MEMORY;
                end else begin
                    state_nx  = ST_FETCH;
                    retire_en = 1'b1;
                end
            end
            ST_MEMORY: begin
                if (bus.mem_ready) begin
                    state_nx  = ST_FETCH;
                    retire_en = 1'b1;
                end
            end
            default: begin
                // Illegal code recovers silently: no load, no retire.
                state_nx = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= '0;
        end else if (ir_ld) begin
            ir_r <= bus.mem_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_r <= '0;
        end else if (cc_ld) begin
            cc_r <= bus.flags_in;
        end
    end

    stump_retire_counter u_retire (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire_en),
        .count (retired_cnt)
    );

    assign bus.state   = state_r;
    assign bus.ir      = ir_r;
    assign bus.cc      = cc_r;
    assign bus.retired = retired_cnt;
    assign bus.stall   = ((state_r == ST_FETCH) || (state_r == ST_MEMORY)) && !bus.mem_ready;

endmodule

// File: tb/tb_stump_sequencer.sv
// Bench for stump_sequencer: an instruction-level model expands each directed
// instruction into its expected per-cycle trace, checked on every cycle.
module tb_stump_sequencer;
    import stump_sequencer_pkg::*;

    typedef struct {
        logic [1:0]  st;
        logic        st_chk;
        logic [15:0] ir;
        logic [3:0]  cc;
        logic [15:0] ret;
        logic        stall;
        logic        stall_chk;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [15:0] m_ir;
    logic [3:0]  m_cc;
    logic [15:0] m_ret;
    exp_t        q[$];

    stump_sequencer_if bus ();

    stump_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Record what this cycle must show, drive the inputs for the coming edge.
    task automatic step(input logic [1:0] st, input logic st_chk, input logic stl,
                        input logic stl_chk, input logic mr, input logic [15:0] md,
                        input logic ce, input logic [3:0] fl);
        exp_t e;
        e.st = st; e.st_chk = st_chk; e.ir = m_ir; e.cc = m_cc; e.ret = m_ret;
        e.stall = stl; e.stall_chk = stl_chk;
        q.push_back(e);
        bus.mem_ready   = mr;
        bus.mem_data_in = md;
        bus.cc_en       = ce;
        bus.flags_in    = fl;
        @(negedge clk);
    endtask

    // One instruction: fw fetch waits, fetch, execute, then mw memory waits and
    // the memory completion cycle when the opcode is load/store.
    task automatic run_instr(input logic [15:0] w, input int unsigned fw,
                             input int unsigned mw, input logic ce, input logic [3:0] fl);
        for (int unsigned i = 0; i < fw; i++)
            step(ST_FETCH, 1'b1, 1'b1, 1'b1, 1'b0, 16'hDEAD, 1'b1, 4'hF);
        step(ST_FETCH, 1'b1, 1'b0, 1'b1, 1'b1, w, 1'b1, 4'hF);
        m_ir = w;
        step(ST_EXECUTE, 1'b1, 1'b0, 1'b1, 1'b0, 16'hDEAD, ce, fl);
        if (ce) m_cc = fl;
        if (w[15:13] == 3'b110) begin
            for (int unsigned i = 0; i < mw; i++)
                step(ST_MEMORY, 1'b1, 1'b1, 1'b1, 1'b0, 16'hDEAD, 1'b1, 4'hF);
            step(ST_MEMORY, 1'b1, 1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b1, 4'hF);
        end
        m_ret = m_ret + 16'd1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.st_chk) chk("state", 16'(bus.state), 16'(e.st));
            chk("ir", bus.ir, e.ir);
            chk("cc", 16'(bus.cc), 16'(e.cc));
            chk("retired", bus.retired, e.ret);
            if (e.stall_chk) chk("stall", 16'(bus.stall), 16'(e.stall));
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        m_ir  = '0;
        m_cc  = '0;
        m_ret = '0;
        rst_n = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.mem_data_in = '0;
        bus.flags_in    = '0;
        bus.cc_en       = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_state", 16'(bus.state), 16'h0000);
        chk("reset_ir", bus.ir, 16'h0000);
        chk("reset_cc", 16'(bus.cc), 16'h0000);
        chk("reset_retired", bus.retired, 16'h0000);
        chk("reset_stall", 16'(bus.stall), 16'h0001);
        rst_n = 1'b1;

        // ADD, then cc load and cc hold
        run_instr(16'h0123, 0, 0, 1'b1, 4'b0100);
        chk("add_ir", bus.ir, 16'h0123);
        chk("add_retired", bus.retired, 16'h0001);
        chk("cc_load", 16'(bus.cc), 16'h0004);
        run_instr(16'h2345, 1, 0, 1'b0, 4'b1111);
        chk("cc_hold", 16'(bus.cc), 16'h0004);

        // LDST with two memory waits
        run_instr(16'hC000, 0, 2, 1'b0, 4'b0000);
        chk("ldst_retired", bus.retired, 16'h0003);
        chk("ldst_state", 16'(bus.state), 16'h0000);

        run_instr(16'hE123, 3, 0, 1'b1, 4'b1010);
        run_instr(16'hD5A5, 2, 1, 1'b1, 4'b0011);
        run_instr(16'hA000, 0, 0, 1'b0, 4'b1100);
        run_instr(16'hC7FF, 1, 3, 1'b1, 4'b1001);
        chk("mix_retired", bus.retired, 16'h0007);
        chk("mix_cc", 16'(bus.cc), 16'h0009);

        // Counter wrap from 16'hFFFF
        m_ret = 16'hFFFF;
        force dut.u_retire.count = 16'hFFFF;
        step(ST_FETCH, 1'b1, 1'b1, 1'b1, 1'b0, 16'hDEAD, 1'b1, 4'hF);
        release dut.u_retire.count;
        run_instr(16'h0042, 0, 0, 1'b0, 4'b0000);
        chk("wrap_retired", bus.retired, 16'h0000);

        // Illegal state recovers to FETCH with ir/cc/retired untouched
        force dut.state_r = ST_ILLEGAL;
        step(ST_ILLEGAL, 1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 4'b0110);
        release dut.state_r;
        step(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b1, 4'b0110);
        chk("illegal_state", 16'(bus.state), 16'h0000);
        chk("illegal_ir", bus.ir, 16'h0042);
        chk("illegal_cc", 16'(bus.cc), 16'h0009);
        chk("illegal_retired", bus.retired, 16'h0000);

        // Async reset in the middle of MEMORY
        run_instr(16'h1111, 0, 0, 1'b0, 4'b0000);
        step(ST_FETCH, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC0AA, 1'b1, 4'hF);
        m_ir = 16'hC0AA;
        step(ST_EXECUTE, 1'b1, 1'b0, 1'b1, 1'b0, 16'hDEAD, 1'b1, 4'b0110);
        m_cc = 4'b0110;
        step(ST_MEMORY, 1'b1, 1'b1, 1'b1, 1'b0, 16'hDEAD, 1'b1, 4'hF);
        bus.mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", 16'(bus.state), 16'h0000);
        chk("async_ir", bus.ir, 16'h0000);
        chk("async_cc", 16'(bus.cc), 16'h0000);
        chk("async_retired", bus.retired, 16'h0000);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        m_ir  = '0;
        m_cc  = '0;
        m_ret = '0;
        rst_n = 1'b1;
        run_instr(16'h4321, 1, 0, 1'b0, 4'b0000);
        chk("post_reset_retired", bus.retired, 16'h0001);
        chk("post_reset_ir", bus.ir, 16'h4321);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
